mont_convert: RTL and testbench

Sequential converter between the normal and Montgomery residue domains (R = 2^WIDTH) for an odd modulus MOD. It sits on both sides of the combinational Montgomery multiplier. Mode 0 lifts an operand into Montgomery form (x·R mod MOD) before multiplication. Mode 1 brings a Montgomery-form result back to the normal domain (x·R⁻¹ mod MOD). Implementation is a bit-serial radix-2 Montgomery multiply with valid/ready handshakes on both ends.

---
 rtl/mont_pkg.sv | 20 ++
 rtl/mont_convert_if.sv | 26 ++
 rtl/mont_step.sv | 25 ++
 rtl/mont_convert.sv | 107 ++++++++++
 tb/tb_mont_convert.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared constants, mode encoding and FSM state type for the Montgomery
// domain converter and the multiplier it serves.
package mont_pkg;

  localparam int          DEF_WIDTH = 32;
  localparam logic [31:0] DEF_MOD   = 32'd998244353;
  // 2^(2*DEF_WIDTH) mod DEF_MOD; must be regenerated if MOD or WIDTH change
  localparam logic [31:0] DEF_R2    = 32'd932051910;

  localparam logic MODE_TO_MONT   = 1'b0;
  localparam logic MODE_FROM_MONT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mont_convert_if.sv
// Operand/result bus of the Montgomery domain converter.
// Both sides use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; valid holds (with stable payload) until then.
interface mont_convert_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: u' = (u + a_bit*b [+ MOD]) / 2.
// Kept combinational so it can be chained for an unrolled variant.
module mont_step
  import mont_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(DEF_MOD)
) (
  input  logic [WIDTH+1:0] u,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH+1:0] u_next
);

  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;

  // u < 2*MOD and b < MOD keep t below 4*MOD, so WIDTH+2 bits never overflow
  always_comb begin
    t_add  = u + (a_bit ? {2'b00, b} : '0);
    t_odd  = t_add[0] ? (t_add + {2'b00, MOD}) : t_add;
    u_next = t_odd >> 1;
  end

endmodule

// File: rtl/mont_convert.sv
// Bit-serial converter between normal and Montgomery domains (R = 2^WIDTH):
// REDC(x * R2) lifts into the domain, REDC(x * 1) brings a value back out.
module mont_convert
  import mont_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(DEF_MOD),
  parameter logic [WIDTH-1:0] R2    = WIDTH'(DEF_R2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mont_convert_if.slave        bus,
  output state_t               state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH+1:0] u_q, u_d;
  logic [WIDTH+1:0] u_step;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  mont_step #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) step_i (
    .u      (u_q),
    .a_bit  (a_q[0]),
    .b      (b_q),
    .u_next (u_step)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    u_d         = u_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_data;
          // The mode only selects the multiplier constant, so it needs no register
          b_d     = (bus.in_mode == MODE_FROM_MONT) ? WIDTH'(1) : R2;
          u_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        u_d   = u_step;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        out_data_d  = (u_q >= {2'b00, MOD}) ? WIDTH'(u_q - {2'b00, MOD})
                                            : u_q[WIDTH-1:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      u_q         <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      u_q         <= u_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mont_convert.sv
// Directed and round-trip checks of mont_convert against an arithmetic
// reference (x*R mod M, x*R^-1 mod M) built from 64-bit modular math.
module tb_mont_convert;
  import mont_pkg::*;

  localparam longint unsigned M  = 64'd998244353;
  localparam longint unsigned RM = 64'h1_0000_0000 % M;

  logic   clk;
  logic   rst_n;
  state_t state;

  mont_convert_if #(.WIDTH(32)) bus ();

  mont_convert dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  longint unsigned rinv;

  typedef struct {
    logic [31:0] x;
    logic        mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned powmod(input longint unsigned base,
                                             input longint unsigned e_in,
                                             input longint unsigned m);
    longint unsigned r, b, e;
    r = 1;
    b = base % m;
    e = e_in;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] to_mont_ref(input logic [31:0] x);
    longint unsigned v;
    v = ((64'(x) % M) * RM) % M;
    return v[31:0];
  endfunction

  function automatic logic [31:0] from_mont_ref(input logic [31:0] x);
    longint unsigned v;
    v = ((64'(x) % M) * rinv) % M;
    return v[31:0];
  endfunction

  // Runs one conversion starting and ending at posedge+1; ready_delay cycles
  // of out_ready low are applied after out_valid rises.
  task automatic do_conv(input logic [31:0] x, input logic mode,
                         input int pre_gap, input int ready_delay,
                         output logic [31:0] res, output int lat);
    int n;
    res = '0;
    lat = 0;
    repeat (pre_gap) begin
      @(posedge clk); #1;
    end
    bus.out_ready = (ready_delay == 0);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_mode  = mode;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_mode  = ~mode;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
      return;
    end
    res = bus.out_data;
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #1;
      check("hold_data", 64'(bus.out_data), 64'(res));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] res, res2, x, held;
    int lat;

    vecs[0] = '{x: 32'd1,          mode: 1'b0, exp: 32'd301989884};
    vecs[1] = '{x: 32'd301989884,  mode: 1'b1, exp: 32'd1};
    vecs[2] = '{x: 32'd0,          mode: 1'b0, exp: 32'd0};
    vecs[3] = '{x: 32'd0,          mode: 1'b1, exp: 32'd0};
    vecs[4] = '{x: 32'd998244352,  mode: 1'b0, exp: 32'd696254469};
    vecs[5] = '{x: 32'hFFFFFFFF,   mode: 1'b0, exp: 32'd630062026};
    vecs[6] = '{x: 32'd998244353,  mode: 1'b0, exp: 32'd0};
    vecs[7] = '{x: 32'd5,          mode: 1'b0, exp: 32'd511705067};

    rinv = powmod(RM, M - 2, M);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_state",     64'(state),         64'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_conv(vecs[i].x, vecs[i].mode, 0, 0, res, lat);
      check($sformatf("vec%0d_data", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
    end
    check("ref_ffff", 64'(to_mont_ref(32'hFFFFFFFF)), 64'(vecs[5].exp));

    // Back-pressure with in_valid pushing during DONE
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd5;
    bus.in_mode   = MODE_TO_MONT;
    @(posedge clk); #1;
    bus.in_data   = 32'd77;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd33);
    held = bus.out_data;
    check("bp_data", 64'(held), 64'd511705067);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_stable", 64'(bus.out_data), 64'(held));
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset in the middle of RUN
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd123;
    bus.in_mode  = MODE_TO_MONT;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("mid_run_state", 64'(state), 64'(RUN));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("async_rst_data", 64'(bus.out_data), 64'd0);
    do_conv(32'd7, MODE_TO_MONT, 0, 0, res, lat);
    check("after_rst_data", 64'(res), 64'(to_mont_ref(32'd7)));
    check("after_rst_latency", 64'(lat), 64'd33);

    // Random round trips with gaps and back-pressure
    for (int i = 0; i < 200; i++) begin
      x = $urandom;
      if (i == 0) x = 32'hFFFFFFFF;
      exp_q.push_back(to_mont_ref(x));
      exp_q.push_back(x % 32'd998244353);
      do_conv(x, MODE_TO_MONT, $urandom_range(0, 3), $urandom_range(0, 3), res, lat);
      check("rt_to", 64'(res), 64'(exp_q.pop_front()));
      check("rt_to_range", 64'(res < 32'd998244353), 64'd1);
      do_conv(res, MODE_FROM_MONT, $urandom_range(0, 3), $urandom_range(0, 3), res2, lat);
      check("rt_back", 64'(res2), 64'(exp_q.pop_front()));
      check("rt_from_ref", 64'(res2), 64'(from_mont_ref(res)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
